tcdm_filter_cfg: RTL and testbench

TCDM_FILTER_CFG -- requirements
Module: tcdm_filter_cfg

---
 rtl/tcdm_filter_cfg_if.sv | 21 ++
 rtl/tcdm_filter_cfg.sv | 155 +++++++++++++++
 tb/tb_tcdm_filter_cfg.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_filter_cfg_if.sv
// Configuration slave bus of the TCDM filter: request, grant and one-cycle response.
interface tcdm_filter_cfg_if;
  logic        req_i;
  logic [31:0] add_i;
  logic        wen_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o;
  logic [31:0] r_rdata_o;
  logic        r_valid_o;

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i,
    input  gnt_o, r_rdata_o, r_valid_o
  );

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i,
    output gnt_o, r_rdata_o, r_valid_o
  );
endinterface

// File: rtl/tcdm_filter_cfg.sv
// TCDM filter configuration block: shadow rule/control registers, a commit FSM that
// waits for the filtered port to drain before applying them, and error capture.
module tcdm_filter_cfg #(
  parameter int unsigned N_RULES       = 8,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  tcdm_filter_cfg_if.slave         cfg,
  input  logic                     filter_busy_i,
  input  logic                     error_i,
  input  logic [31:0]              err_add_i,
  output logic [N_RULES-1:0][31:0] RULES_o,
  output logic                     filter_en_o,
  output logic                     supervisor_mode_o,
  output logic                     hold_o,
  output logic                     irq_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned CTRL_W = 4;

  typedef logic [OFF_W-1:0] off_t;

  localparam off_t               OFF_CTRL     = 6'h08;
  localparam off_t               OFF_COMMIT   = 6'h09;
  localparam off_t               OFF_STATUS   = 6'h0A;
  localparam off_t               OFF_ERR_ADDR = 6'h0B;
  localparam off_t               OFF_ERR_CNT  = 6'h0C;
  localparam logic [DATA_W-1:0]  BAD_DATA     = 32'hBADE5505;
  localparam logic [CTRL_W-1:0]  CTRL_RST     = 4'b0010;

  typedef enum logic [1:0] {IDLE, WAIT, APPLY} state_e;

  state_e                         state_q, state_d;
  logic [N_RULES-1:0][DATA_W-1:0] shadow_rule_q;
  logic [CTRL_W-1:0]              shadow_ctrl_q;
  logic                           active_lock_q, active_irq_en_q, irq_en_d;
  logic                           err_sticky_q, err_sticky_d;
  logic [DATA_W-1:0]              err_addr_q, err_addr_d;
  logic [ERR_CNT_WIDTH-1:0]       err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0]              rdata_d;
  off_t                           offset;
  logic                           rd_en, wr_en, cfg_wr_en, commit_go, status_clr;
  logic                           unused_addr_bits;

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [3:0]        be);
    logic [DATA_W-1:0] merged;
    merged = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = new_w[8*b +: 8];
    end
    return merged;
  endfunction

  assign offset           = cfg.add_i[7:2];
  assign unused_addr_bits = ^{cfg.add_i[31:8], cfg.add_i[1:0]};
  assign cfg.gnt_o        = cfg.req_i;
  assign rd_en            = cfg.req_i & cfg.wen_i;
  assign wr_en            = cfg.req_i & ~cfg.wen_i & (|cfg.be_i);
  // Lock freezes the configuration path; status clear stays reachable.
  assign cfg_wr_en        = wr_en & ~active_lock_q;
  assign commit_go        = cfg_wr_en & (offset == OFF_COMMIT) & cfg.wdata_i[0];
  assign status_clr       = wr_en & (offset == OFF_STATUS) & cfg.wdata_i[1];

  // Commit sequencing: wait for the filtered port to drain, then apply for one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_go) state_d = WAIT;
      WAIT:    if (!filter_busy_i) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error capture; an error arriving with a clear restarts the record from that error.
  always_comb begin
    err_sticky_d = status_clr ? 1'b0 : err_sticky_q;
    err_addr_d   = status_clr ? '0 : err_addr_q;
    err_cnt_d    = status_clr ? '0 : err_cnt_q;
    if (error_i) begin
      if (!err_sticky_d) err_addr_d = err_add_i;
      err_sticky_d = 1'b1;
      if (err_cnt_d != '1) err_cnt_d = err_cnt_d + ERR_CNT_WIDTH'(1);
    end
    irq_en_d = (state_q == APPLY) ? shadow_ctrl_q[3] : active_irq_en_q;
  end

  always_comb begin
    rdata_d = BAD_DATA;
    for (int unsigned i = 0; i < N_RULES; i++) begin
      if (offset == off_t'(i)) rdata_d = shadow_rule_q[i];
    end
    case (offset)
      OFF_CTRL:     rdata_d = DATA_W'(shadow_ctrl_q);
      OFF_COMMIT:   rdata_d = '0;
      OFF_STATUS:   rdata_d = DATA_W'({active_lock_q, err_sticky_q, state_q != IDLE});
      OFF_ERR_ADDR: rdata_d = err_addr_q;
      OFF_ERR_CNT:  rdata_d = DATA_W'(err_cnt_q);
      default:      ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      shadow_rule_q     <= '0;
      shadow_ctrl_q     <= CTRL_RST;
      RULES_o           <= '0;
      filter_en_o       <= CTRL_RST[0];
      supervisor_mode_o <= CTRL_RST[1];
      active_lock_q     <= CTRL_RST[2];
      active_irq_en_q   <= CTRL_RST[3];
      err_sticky_q      <= 1'b0;
      err_addr_q        <= '0;
      err_cnt_q         <= '0;
      cfg.r_valid_o     <= 1'b0;
      cfg.r_rdata_o     <= '0;
      hold_o            <= 1'b0;
      irq_o             <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_o        <= (state_d != IDLE);
      cfg.r_valid_o <= cfg.req_i;
      if (rd_en) cfg.r_rdata_o <= rdata_d;

      if (cfg_wr_en) begin
        for (int unsigned i = 0; i < N_RULES; i++) begin
          if (offset == off_t'(i))
            shadow_rule_q[i] <= be_merge(shadow_rule_q[i], cfg.wdata_i, cfg.be_i);
        end
        if (offset == OFF_CTRL && cfg.be_i[0]) shadow_ctrl_q <= cfg.wdata_i[CTRL_W-1:0];
      end

      // Apply samples the shadow values present during the APPLY cycle.
      if (state_q == APPLY) begin
        RULES_o           <= shadow_rule_q;
        filter_en_o       <= shadow_ctrl_q[0];
        supervisor_mode_o <= shadow_ctrl_q[1];
        active_lock_q     <= shadow_ctrl_q[2];
      end
      active_irq_en_q <= irq_en_d;

      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
      err_cnt_q    <= err_cnt_d;
      irq_o        <= err_sticky_d & irq_en_d;
    end
  end

endmodule

// File: tb/tb_tcdm_filter_cfg.sv
// Directed bench for tcdm_filter_cfg: per-cycle comparison against a register-map model
// plus literal expectations for commit, errors, lock, unmapped reads and reset.
module tb_tcdm_filter_cfg;

  logic              clk = 1'b0;
  logic              rst;
  logic              busy, err;
  logic [31:0]       err_add;
  logic [3:0][31:0]  rules;
  logic              fen, sup, hold, irq;
  int                checks = 0;
  int                failures = 0;
  bit                chk_en = 1'b0;

  tcdm_filter_cfg_if bus ();

  tcdm_filter_cfg #(.N_RULES(4), .ERR_CNT_WIDTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .cfg               (bus),
    .filter_busy_i     (busy),
    .error_i           (err),
    .err_add_i         (err_add),
    .RULES_o           (rules),
    .filter_en_o       (fen),
    .supervisor_mode_o (sup),
    .hold_o            (hold),
    .irq_o             (irq)
  );

  always #5 clk = ~clk;

  // Register-map model: shadow/active copies, commit phase (0 none, 1 waiting, 2 applying).
  logic [3:0][31:0] m_sh, m_act;
  logic [3:0]       m_shc, m_actc;
  logic             m_sticky, m_valid, m_rd;
  logic [31:0]      m_eaddr, m_rdata;
  int unsigned      m_ecnt;
  int               m_phase;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [5:0] off;
    off = a[7:2];
    if (off < 6'd4) return m_sh[off[1:0]];
    case (off)
      6'h08:   return {28'b0, m_shc};
      6'h09:   return 32'h0;
      6'h0A:   return {29'b0, m_actc[2], m_sticky, m_phase != 0};
      6'h0B:   return m_eaddr;
      6'h0C:   return m_ecnt;
      default: return 32'hBADE5505;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [5:0]  off;
    logic [31:0] rv;
    logic        wr, lock;
    if (rst) begin
      m_sh = '0; m_act = '0; m_shc = 4'b0010; m_actc = 4'b0010;
      m_sticky = 1'b0; m_eaddr = '0; m_ecnt = 0; m_phase = 0;
      m_valid = 1'b0; m_rd = 1'b0; m_rdata = '0;
    end else begin
      rv   = model_read(bus.add_i);
      off  = bus.add_i[7:2];
      wr   = bus.req_i && !bus.wen_i && (bus.be_i != 4'h0);
      lock = m_actc[2];
      m_valid = bus.req_i;
      m_rd    = bus.req_i && bus.wen_i;
      if (m_rd) m_rdata = rv;
      if (m_phase == 2) begin
        m_act = m_sh; m_actc = m_shc; m_phase = 0;
      end else if (m_phase == 1) begin
        if (!busy) m_phase = 2;
      end else if (wr && !lock && off == 6'h09 && bus.wdata_i[0]) begin
        m_phase = 1;
      end
      if (wr && !lock) begin
        if (off < 6'd4)
          for (int b = 0; b < 4; b++)
            if (bus.be_i[b]) m_sh[off[1:0]][8*b +: 8] = bus.wdata_i[8*b +: 8];
        if (off == 6'h08 && bus.be_i[0]) m_shc = bus.wdata_i[3:0];
      end
      if (wr && off == 6'h0A && bus.wdata_i[1]) begin
        m_sticky = 1'b0; m_eaddr = '0; m_ecnt = 0;
      end
      if (err) begin
        if (!m_sticky) m_eaddr = err_add;
        m_sticky = 1'b1;
        if (m_ecnt < 65535) m_ecnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt", 128'(bus.gnt_o), 128'(bus.req_i));
      chk("r_valid", 128'(bus.r_valid_o), 128'(m_valid));
      if (m_valid && m_rd) chk("r_rdata", 128'(bus.r_rdata_o), 128'(m_rdata));
      chk("hold", 128'(hold), 128'(m_phase != 0));
      chk("irq", 128'(irq), 128'(m_sticky & m_actc[3]));
      chk("filter_en", 128'(fen), 128'(m_actc[0]));
      chk("supervisor", 128'(sup), 128'(m_actc[1]));
      chk("rules", 128'(rules), 128'(m_act));
    end
  end

  task automatic acc(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] d);
    @(posedge clk); #1;
    bus.req_i = 1'b1; bus.wen_i = wen; bus.add_i = a; bus.wdata_i = wd; bus.be_i = be;
    @(posedge clk); #1;
    bus.req_i = 1'b0; bus.wen_i = 1'b1; bus.be_i = 4'h0;
    d = bus.r_rdata_o;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    acc(1'b0, a, wd, 4'hF, dummy);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    acc(1'b1, a, 32'h0, 4'h0, d);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] dummy;
    rst = 1'b1; busy = 1'b0; err = 1'b0; err_add = '0;
    bus.req_i = 1'b0; bus.wen_i = 1'b1; bus.add_i = '0; bus.wdata_i = '0; bus.be_i = 4'h0;
    cycles(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_supervisor", 128'(sup), 128'(1'b1));
    chk("reset_filter_en", 128'(fen), 128'(1'b0));
    chk("reset_rdata", 128'(bus.r_rdata_o), 128'(32'h0));
    chk("reset_rules", 128'(rules), 128'(0));

    // Basic commit with the filtered port idle
    wr(32'h00, 32'h1234_5671);
    wr(32'h20, 32'h1);
    wr(32'h24, 32'h1);
    chk("commit_hold_c1", 128'(hold), 128'(1'b1));
    cycles(1);
    chk("commit_hold_c2", 128'(hold), 128'(1'b1));
    chk("commit_rule_c2", 128'(rules[0]), 128'(32'h0));
    cycles(1);
    chk("commit_hold_c3", 128'(hold), 128'(1'b0));
    chk("commit_rule_c3", 128'(rules[0]), 128'(32'h1234_5671));
    chk("commit_fen_c3", 128'(fen), 128'(1'b1));

    // Commit stalled by a busy filter; partial byte-enable shadow write
    busy = 1'b1;
    acc(1'b0, 32'h04, 32'hA5A5_0001, 4'b0011, dummy);
    wr(32'h24, 32'h1);
    for (int i = 0; i < 5; i++) begin
      rd(32'h28, d);
      chk("busy_status", 128'(d), 128'(32'h1));
    end
    chk("busy_rule1_old", 128'(rules[1]), 128'(32'h0));
    busy = 1'b0;
    cycles(1);
    chk("busy_hold_apply", 128'(hold), 128'(1'b1));
    cycles(1);
    chk("busy_rule1_new", 128'(rules[1]), 128'(32'h0000_0001));

    // Error capture with interrupt enabled
    wr(32'h20, 32'h9);
    wr(32'h24, 32'h1);
    cycles(2);
    @(posedge clk); #1; err = 1'b1; err_add = 32'h1C00_0100;
    @(posedge clk); #1; err_add = 32'h1C00_0200;
    @(posedge clk); #1; err_add = 32'h1C00_0300;
    @(posedge clk); #1; err = 1'b0;
    rd(32'h2C, d); chk("err_addr_first", 128'(d), 128'(32'h1C00_0100));
    rd(32'h30, d); chk("err_cnt_3", 128'(d), 128'(32'h3));
    rd(32'h28, d); chk("err_status", 128'(d), 128'(32'h2));
    chk("err_irq", 128'(irq), 128'(1'b1));
    wr(32'h28, 32'h2);
    chk("clr_irq", 128'(irq), 128'(1'b0));
    rd(32'h30, d); chk("clr_cnt", 128'(d), 128'(32'h0));
    rd(32'h2C, d); chk("clr_addr", 128'(d), 128'(32'h0));

    // Clear and a new error in the same cycle: the error is kept
    @(posedge clk); #1; err = 1'b1; err_add = 32'h1C00_0500;
    @(posedge clk); #1;
    err_add = 32'h1C00_0400;
    bus.req_i = 1'b1; bus.wen_i = 1'b0; bus.add_i = 32'h28; bus.wdata_i = 32'h2; bus.be_i = 4'hF;
    @(posedge clk); #1;
    err = 1'b0; bus.req_i = 1'b0; bus.wen_i = 1'b1; bus.be_i = 4'h0;
    rd(32'h2C, d); chk("race_addr", 128'(d), 128'(32'h1C00_0400));
    rd(32'h30, d); chk("race_cnt", 128'(d), 128'(32'h1));
    wr(32'h28, 32'h2);

    // Unmapped and out-of-range rule reads; high address bits ignored
    rd(32'h3C, d); chk("unmapped_3c", 128'(d), 128'(32'hBADE_5505));
    rd(32'h1C, d); chk("rule7_oob", 128'(d), 128'(32'hBADE_5505));
    rd(32'h10, d); chk("rule4_oob", 128'(d), 128'(32'hBADE_5505));
    rd(32'hFFFF_FF20, d); chk("ctrl_alias", 128'(d), 128'(32'h9));
    wr(32'h3C, 32'hFFFF_FFFF);

    // Lock: further configuration writes and commits are dropped
    wr(32'h20, 32'h4);
    wr(32'h24, 32'h1);
    cycles(2);
    wr(32'h00, 32'hDEAD_BEEF);
    wr(32'h24, 32'h1);
    chk("lock_no_hold", 128'(hold), 128'(1'b0));
    rd(32'h00, d); chk("lock_shadow", 128'(d), 128'(32'h1234_5671));
    rd(32'h28, d); chk("lock_status", 128'(d), 128'(32'h4));
    chk("lock_rule0", 128'(rules[0]), 128'(32'h1234_5671));
    pulse_rst();
    rd(32'h28, d); chk("unlock_status", 128'(d), 128'(32'h0));
    chk("unlock_sup", 128'(sup), 128'(1'b1));

    // Reset while waiting for the filter to drain
    busy = 1'b1;
    wr(32'h08, 32'h55);
    wr(32'h24, 32'h1);
    cycles(2);
    chk("wait_hold", 128'(hold), 128'(1'b1));
    pulse_rst();
    chk("rst_wait_hold", 128'(hold), 128'(1'b0));
    chk("rst_wait_rules", 128'(rules), 128'(0));
    busy = 1'b0;
    cycles(3);
    rd(32'h08, d); chk("rst_wait_shadow", 128'(d), 128'(32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
